// File: rtl/cpu_chk_pkg.sv
// rtl/cpu_chk_pkg.sv - shared types and helpers for the CPU lane checker
// Contents:
//   chk_state_e : per-lane watchdog FSM states
//   lane_lsb    : LSB index of lane 'lane' in a flat NUM_CH*WIDTH bus
package cpu_chk_pkg;

    typedef enum logic [1:0] {IDLE, STALL, TRIP} chk_state_e;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/cpu_lane_pipe.sv
// rtl/cpu_lane_pipe.sv - one lane: valid/ready register pipeline plus stall watchdog
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   chk_en                     : watchdog enable (0 holds FSM in IDLE, cnt 0)
//   s_tdata/s_tvalid/s_tready  : upstream side of the lane
//   m_tdata/m_tvalid/m_tready  : downstream side of the lane (registered)
//   trip                       : one-cycle pulse on the edge the FSM enters TRIP
module cpu_lane_pipe
    import cpu_chk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PIPE_DEPTH = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             trip
);

    localparam int                    LAST     = PIPE_DEPTH - 1;
    localparam int                    CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PIPE_DEPTH-1:0] ONES     = '1;

    logic [PIPE_DEPTH-1:0] vld_q;
    logic [WIDTH-1:0]      data_q  [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] in_vld;
    logic [WIDTH-1:0]      in_data [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] can_load;

    // Stage 0 is fed from the lane input, every later stage from its predecessor.
    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign in_vld[k]  = s_tvalid;
            assign in_data[k] = s_tdata;
        end else begin : g_next
            assign in_vld[k]  = vld_q[k-1];
            assign in_data[k] = data_q[k-1];
        end
    end

    // Stage k may load unless it and every stage after it are full while the
    // output is blocked. Written in closed form to avoid a combinational chain
    // through can_load itself.
    always_comb begin
        can_load = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            can_load[k] = m_tready | ~(&(vld_q | ~(ONES << k)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (can_load[k]) begin
                    vld_q[k] <= in_vld[k];
                    if (in_vld[k]) begin
                        data_q[k] <= in_data[k];
                    end
                end
            end
        end
    end

    assign s_tready = can_load[0];
    assign m_tdata  = data_q[LAST];
    assign m_tvalid = vld_q[LAST];

    // Watchdog
    chk_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = m_tvalid & ~m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!chk_en) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        state <= STALL;
                        cnt   <= CNT_W'(1);
                    end
                end
                STALL: begin
                    if (!stall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= TRIP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRIP: begin
                    // Leave only once the output moves or drains.
                    if (!stall) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Decoded ahead of the edge so the sticky flag rises on the same edge
    // that moves the FSM into TRIP.
    assign trip = chk_en & (state == STALL) & stall & (cnt == CNT_LAST);

endmodule

// File: rtl/cpu_lane_checker.sv
// rtl/cpu_lane_checker.sv - NUM_CH independent CPU lanes with stall watchdog and error count
// Ports:
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   cpu_sig_i/vld_i/rdy_o     : per-lane input stream (lane c at [c*WIDTH +: WIDTH])
//   cpu_sig_o/vld_o/rdy_i     : per-lane output stream, registered
//   chk_en_i                  : watchdog enable
//   chk_clr_i                 : synchronous clear of flags and error count
//   cpu_check_o               : sticky per-lane timeout flags
//   chk_err_cnt_o             : saturating count of timeout events across lanes
module cpu_lane_checker
    import cpu_chk_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 8,
    parameter int PIPE_DEPTH = 2,
    parameter int TIMEOUT    = 16,
    parameter int ERR_W      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH*WIDTH-1:0] cpu_sig_i,
    input  logic [NUM_CH-1:0]       cpu_vld_i,
    output logic [NUM_CH-1:0]       cpu_rdy_o,
    output logic [NUM_CH*WIDTH-1:0] cpu_sig_o,
    output logic [NUM_CH-1:0]       cpu_vld_o,
    input  logic [NUM_CH-1:0]       cpu_rdy_i,
    input  logic                    chk_en_i,
    input  logic                    chk_clr_i,
    output logic [NUM_CH-1:0]       cpu_check_o,
    output logic [ERR_W-1:0]        chk_err_cnt_o
);

    localparam int               TRIP_W  = $clog2(NUM_CH + 1);
    localparam int               SUM_W   = ERR_W + TRIP_W;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [NUM_CH-1:0] trip;
    logic [NUM_CH-1:0] lane_rdy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        localparam int LSB = lane_lsb(c, WIDTH);

        cpu_lane_pipe #(
            .WIDTH      (WIDTH),
            .PIPE_DEPTH (PIPE_DEPTH),
            .TIMEOUT    (TIMEOUT)
        ) u_pipe (
            .clk      (clk_i),
            .rst      (rst_i),
            .chk_en   (chk_en_i),
            .s_tdata  (cpu_sig_i[LSB +: WIDTH]),
            .s_tvalid (cpu_vld_i[c]),
            .s_tready (lane_rdy[c]),
            .m_tdata  (cpu_sig_o[LSB +: WIDTH]),
            .m_tvalid (cpu_vld_o[c]),
            .m_tready (cpu_rdy_i[c]),
            .trip     (trip[c])
        );
    end

    // Hold off producers for the whole reset window, not just until the
    // pipe registers clear.
    assign cpu_rdy_o = rst_i ? '0 : lane_rdy;

    logic [SUM_W-1:0] trip_cnt;
    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] err_next;

    // A clear coinciding with new trips restarts the count from those trips.
    always_comb begin
        trip_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            trip_cnt = trip_cnt + SUM_W'(trip[i]);
        end
        err_sum  = (chk_clr_i ? '0 : SUM_W'(chk_err_cnt_o)) + trip_cnt;
        err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_check_o   <= '0;
            chk_err_cnt_o <= '0;
        end else begin
            cpu_check_o   <= (chk_clr_i ? '0 : cpu_check_o) | trip;
            chk_err_cnt_o <= err_next;
        end
    end

endmodule

// File: tb/tb_cpu_lane_checker.sv
// tb/tb_cpu_lane_checker.sv - self-checking bench for cpu_lane_checker
module tb_cpu_lane_checker;

    localparam int NUM_CH     = 4;
    localparam int WIDTH      = 8;
    localparam int PIPE_DEPTH = 2;
    localparam int TIMEOUT    = 16;
    localparam int ERR_W      = 8;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic [NUM_CH*WIDTH-1:0] cpu_sig_i;
    logic [NUM_CH-1:0]       cpu_vld_i;
    logic [NUM_CH-1:0]       cpu_rdy_o;
    logic [NUM_CH*WIDTH-1:0] cpu_sig_o;
    logic [NUM_CH-1:0]       cpu_vld_o;
    logic [NUM_CH-1:0]       cpu_rdy_i;
    logic                    chk_en_i;
    logic                    chk_clr_i;
    logic [NUM_CH-1:0]       cpu_check_o;
    logic [ERR_W-1:0]        chk_err_cnt_o;

    always #5 clk = ~clk;

    cpu_lane_checker #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .PIPE_DEPTH(PIPE_DEPTH),
        .TIMEOUT(TIMEOUT), .ERR_W(ERR_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cpu_sig_i    (cpu_sig_i),
        .cpu_vld_i    (cpu_vld_i),
        .cpu_rdy_o    (cpu_rdy_o),
        .cpu_sig_o    (cpu_sig_o),
        .cpu_vld_o    (cpu_vld_o),
        .cpu_rdy_i    (cpu_rdy_i),
        .chk_en_i     (chk_en_i),
        .chk_clr_i    (chk_clr_i),
        .cpu_check_o  (cpu_check_o),
        .chk_err_cnt_o(chk_err_cnt_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: each lane is an ordered list of accepted items tagged
    // with the edge that accepted them. An item can leave once it is the oldest
    // and PIPE_DEPTH-1 further edges have passed; a lane holds at most
    // PIPE_DEPTH items. The watchdog is a run-length of stalled enabled edges.
    logic [WIDTH-1:0]  md   [NUM_CH][PIPE_DEPTH];
    int                me   [NUM_CH][PIPE_DEPTH];
    int                mcnt [NUM_CH];
    int                run  [NUM_CH];
    bit                tripped [NUM_CH];
    int                obs_xfers [NUM_CH];
    logic [NUM_CH-1:0] m_flags;
    int                m_err;
    int                edge_cnt = 0;

    function automatic logic [NUM_CH-1:0] exp_vld();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++)
            v[c] = (mcnt[c] > 0) && (me[c][0] + PIPE_DEPTH - 1 <= edge_cnt);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_rdy();
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++)
            r[c] = !rst_i && (cpu_rdy_i[c] || mcnt[c] < PIPE_DEPTH);
        return r;
    endfunction

    function automatic logic [NUM_CH*WIDTH-1:0] lane_mask(input logic [NUM_CH-1:0] v);
        logic [NUM_CH*WIDTH-1:0] m;
        m = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (v[c]) m[c*WIDTH +: WIDTH] = '1;
        return m;
    endfunction

    function automatic logic [NUM_CH*WIDTH-1:0] exp_sig();
        logic [NUM_CH*WIDTH-1:0] s;
        s = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (mcnt[c] > 0) s[c*WIDTH +: WIDTH] = md[c][0];
        return s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mcnt[c] = 0; run[c] = 0; tripped[c] = 0;
        end
        m_flags = '0;
        m_err   = 0;
    endtask

    task automatic model_edge();
        logic [NUM_CH-1:0] v, r, tr;
        int ntr;
        if (rst_i) begin
            model_reset();
        end else begin
            v = exp_vld(); r = exp_rdy(); tr = '0; ntr = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!chk_en_i || !(v[c] && !cpu_rdy_i[c])) begin
                    run[c] = 0; tripped[c] = 0;
                end else if (!tripped[c]) begin
                    run[c]++;
                    if (run[c] == TIMEOUT) begin
                        tr[c] = 1'b1; tripped[c] = 1; ntr++;
                    end
                end
                if (v[c] && cpu_rdy_i[c]) begin
                    for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
                        md[c][i] = md[c][i+1]; me[c][i] = me[c][i+1];
                    end
                    mcnt[c]--;
                end
                if (cpu_vld_i[c] && r[c] && mcnt[c] < PIPE_DEPTH) begin
                    md[c][mcnt[c]] = cpu_sig_i[c*WIDTH +: WIDTH];
                    me[c][mcnt[c]] = edge_cnt + 1;
                    mcnt[c]++;
                end
            end
            m_flags = (chk_clr_i ? '0 : m_flags) | tr;
            m_err   = (chk_clr_i ? 0 : m_err) + ntr;
            if (m_err > ERR_MAX) m_err = ERR_MAX;
        end
        edge_cnt++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0]       v;
        logic [NUM_CH*WIDTH-1:0] m;
        v = exp_vld();
        m = lane_mask(v);
        chk("vld_o", 64'(cpu_vld_o), 64'(v));
        chk("sig_o", 64'(cpu_sig_o & m), 64'(exp_sig() & m));
        chk("rdy_o", 64'(cpu_rdy_o), 64'(exp_rdy()));
        chk("check_o", 64'(cpu_check_o), 64'(m_flags));
        chk("err_cnt", 64'(chk_err_cnt_o), 64'(m_err));
        for (int c = 0; c < NUM_CH; c++)
            if (cpu_vld_o[c] === 1'b1 && cpu_rdy_i[c] === 1'b1) obs_xfers[c]++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_data();
        for (int c = 0; c < NUM_CH; c++) cpu_sig_i[c*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    // Park one item at the output of every lane selected by mask.
    task automatic load(input logic [NUM_CH-1:0] mask);
        rand_data();
        cpu_vld_i = mask;
        tick();
        cpu_vld_i = '0;
        tick();
    endtask

    // Empty every lane, re-enable the watchdog and clear flags/count.
    task automatic drain();
        cpu_vld_i = '0; cpu_rdy_i = '1; chk_en_i = 1'b1;
        ticks(4);
        chk_clr_i = 1'b1;
        tick();
        chk_clr_i = 1'b0;
    endtask

    logic [NUM_CH*WIDTH-1:0] first_data;

    initial begin
        rst_i = 1'b1; cpu_sig_i = '0; cpu_vld_i = '0; cpu_rdy_i = '1;
        chk_en_i = 1'b1; chk_clr_i = 1'b0;
        model_reset();
        for (int c = 0; c < NUM_CH; c++) obs_xfers[c] = 0;

        // Reset state, with downstream ready to show rdy_o is gated by reset.
        #2;
        check_outputs();
        tick();
        rst_i = 1'b0;
        tick();

        // Back-to-back streaming, 8 items per lane.
        for (int c = 0; c < NUM_CH; c++) obs_xfers[c] = 0;
        for (int i = 0; i < 8; i++) begin
            rand_data(); cpu_vld_i = '1;
            tick();
        end
        cpu_vld_i = '0;
        ticks(3);
        for (int c = 0; c < NUM_CH; c++) chk("stream_items", 64'(obs_xfers[c]), 64'd8);
        chk("stream_flags", 64'(cpu_check_o), 64'd0);

        // Random traffic across all lanes.
        for (int i = 0; i < 300; i++) begin
            rand_data();
            cpu_vld_i = NUM_CH'($urandom);
            for (int c = 0; c < NUM_CH; c++) cpu_rdy_i[c] = ($urandom_range(0, 9) < 7);
            chk_en_i  = ($urandom_range(0, 19) != 0);
            chk_clr_i = chk_en_i && ($urandom_range(0, 49) == 0);
            tick();
        end
        chk_clr_i = 1'b0;

        // Lane 1: 15 stalled cycles are harmless, 16 trip.
        drain();
        load(4'b0010);
        cpu_rdy_i = 4'b1101;
        ticks(15);
        chk("stall15_flag", 64'(cpu_check_o), 64'd0);
        cpu_rdy_i = '1;
        tick();
        load(4'b0010);
        cpu_rdy_i = 4'b1101;
        ticks(15);
        chk("stall15b_flag", 64'(cpu_check_o), 64'd0);
        tick();
        chk("stall16_flag", 64'(cpu_check_o), 64'b0010);
        chk("stall16_cnt", 64'(chk_err_cnt_o), 64'd1);

        // Lanes 0 and 3 trip together.
        drain();
        load(4'b1001);
        cpu_rdy_i = 4'b0110;
        ticks(16);
        chk("dual_flag", 64'(cpu_check_o), 64'b1001);
        chk("dual_cnt", 64'(chk_err_cnt_o), 64'd2);

        // 300 trips saturate the counter at 255.
        drain();
        load('1);
        cpu_rdy_i = '0;
        for (int r = 0; r < 75; r++) begin
            ticks(16);
            chk_en_i = 1'b0;
            tick();
            chk_en_i = 1'b1;
        end
        chk("sat_cnt", 64'(chk_err_cnt_o), 64'(ERR_MAX));

        // Clear on the same edge lane 2 trips, lane 0 flag already set.
        drain();
        load(4'b0001);
        cpu_rdy_i = 4'b1110;
        ticks(16);
        chk("pre_clr_flag", 64'(cpu_check_o), 64'b0001);
        cpu_rdy_i = '1;
        load(4'b0100);
        cpu_rdy_i = 4'b1011;
        ticks(15);
        chk_clr_i = 1'b1;
        tick();
        chk_clr_i = 1'b0;
        chk("clr_trip_flag", 64'(cpu_check_o), 64'b0100);
        chk("clr_trip_cnt", 64'(chk_err_cnt_o), 64'd1);

        // Watchdog disabled through a 40-cycle stall, then re-enabled.
        drain();
        load(4'b0010);
        chk_en_i  = 1'b0;
        cpu_rdy_i = 4'b1101;
        ticks(40);
        chk("dis_flag", 64'(cpu_check_o), 64'd0);
        chk_en_i = 1'b1;
        ticks(15);
        chk("reen15_flag", 64'(cpu_check_o), 64'd0);
        tick();
        chk("reen16_flag", 64'(cpu_check_o), 64'b0010);

        // Asynchronous reset with every pipe full.
        drain();
        cpu_rdy_i = '0;
        for (int i = 0; i < 3; i++) begin
            rand_data(); cpu_vld_i = '1;
            tick();
        end
        chk("full_vld", 64'(cpu_vld_o), 64'hF);
        cpu_rdy_i = '1;
        rst_i = 1'b1;
        #1;
        chk("async_vld", 64'(cpu_vld_o), 64'd0);
        chk("async_sig", 64'(cpu_sig_o), 64'd0);
        chk("async_rdy", 64'(cpu_rdy_o), 64'd0);
        tick();
        rst_i = 1'b0; cpu_vld_i = '0;
        tick();
        rand_data(); first_data = cpu_sig_i; cpu_vld_i = '1;
        tick();
        cpu_vld_i = '0;
        tick();
        chk("post_rst_vld", 64'(cpu_vld_o), 64'hF);
        chk("post_rst_sig", 64'(cpu_sig_o), 64'(first_data));
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
